// File: rtl/pilot_interp_seq.sv
`default_nettype none
// ============================================================================
// Module      : pilot_interp_seq
// Description : Sequences one OFDM symbol of NRS pilot estimates into a
//               12-subcarrier stream of bypassed pilots and 2a+b / a+2b sums.
// Revision    : 1.0 - initial release
// ============================================================================
module pilot_interp_seq #(
  parameter int EST_WIDTH    = 18,
  parameter int SUM_WIDTH    = 20,
  parameter int NUM_PILOTS   = 4,
  parameter int NUM_SC       = 12,
  parameter int SC_IDX_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    pilot_valid,
  output logic                    pilot_ready,
  input  logic [EST_WIDTH-1:0]    pilot_re,
  input  logic [EST_WIDTH-1:0]    pilot_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_WIDTH-1:0]    sum_re,
  output logic [SUM_WIDTH-1:0]    sum_im,
  output logic                    bypass,
  output logic [SC_IDX_WIDTH-1:0] sc_idx,
  output logic                    done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_A     = 3'd1;
  localparam logic [2:0] S_EMIT_P    = 3'd2;
  localparam logic [2:0] S_GET_B     = 3'd3;
  localparam logic [2:0] S_EMIT_1    = 3'd4;
  localparam logic [2:0] S_EMIT_2    = 3'd5;
  localparam logic [2:0] S_EMIT_TAIL = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam int                      PCNT_WIDTH  = $clog2(NUM_PILOTS + 1);
  localparam logic [PCNT_WIDTH-1:0]   C_NUM_PILOT = PCNT_WIDTH'(NUM_PILOTS);
  localparam logic [SC_IDX_WIDTH-1:0] C_LAST_SC   = SC_IDX_WIDTH'(NUM_SC - 1);
  localparam int                      EXT_BITS    = SUM_WIDTH - EST_WIDTH;

  logic [2:0]              state_q, state_d;
  logic [EST_WIDTH-1:0]    a_re_q, a_re_d, a_im_q, a_im_d;
  logic [EST_WIDTH-1:0]    b_re_q, b_re_d, b_im_q, b_im_d;
  logic [PCNT_WIDTH-1:0]   pcnt_q, pcnt_d;
  logic [SC_IDX_WIDTH-1:0] sc_idx_q, sc_idx_d;
  logic                    pilot_ready_q, pilot_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    bypass_q, bypass_d;
  logic                    done_q, done_d;
  logic [SUM_WIDTH-1:0]    sum_re_q, sum_re_d, sum_im_q, sum_im_d;

  logic                    in_xfer, out_xfer;
  logic [SUM_WIDTH-1:0]    ext_a_re, ext_a_im, ext_b_re, ext_b_im;

  assign in_xfer  = pilot_valid & pilot_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // Outputs are computed from next-state values so every port comes from a flop.
  assign ext_a_re = {{EXT_BITS{a_re_d[EST_WIDTH-1]}}, a_re_d};
  assign ext_a_im = {{EXT_BITS{a_im_d[EST_WIDTH-1]}}, a_im_d};
  assign ext_b_re = {{EXT_BITS{b_re_d[EST_WIDTH-1]}}, b_re_d};
  assign ext_b_im = {{EXT_BITS{b_im_d[EST_WIDTH-1]}}, b_im_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      a_re_q        <= '0;
      a_im_q        <= '0;
      b_re_q        <= '0;
      b_im_q        <= '0;
      pcnt_q        <= '0;
      sc_idx_q      <= '0;
      pilot_ready_q <= 1'b0;
      out_valid_q   <= 1'b0;
      bypass_q      <= 1'b0;
      done_q        <= 1'b0;
      sum_re_q      <= '0;
      sum_im_q      <= '0;
    end else begin
      state_q       <= state_d;
      a_re_q        <= a_re_d;
      a_im_q        <= a_im_d;
      b_re_q        <= b_re_d;
      b_im_q        <= b_im_d;
      pcnt_q        <= pcnt_d;
      sc_idx_q      <= sc_idx_d;
      pilot_ready_q <= pilot_ready_d;
      out_valid_q   <= out_valid_d;
      bypass_q      <= bypass_d;
      done_q        <= done_d;
      sum_re_q      <= sum_re_d;
      sum_im_q      <= sum_im_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_re_d   = a_re_q;
    a_im_d   = a_im_q;
    b_re_d   = b_re_q;
    b_im_d   = b_im_q;
    pcnt_d   = pcnt_q;
    sc_idx_d = sc_idx_q;
    if (out_xfer && (sc_idx_q != C_LAST_SC)) begin
      sc_idx_d = sc_idx_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_GET_A;
          sc_idx_d = '0;
          pcnt_d   = '0;
        end
      end
      S_GET_A: begin
        if (in_xfer) begin
          a_re_d  = pilot_re;
          a_im_d  = pilot_im;
          pcnt_d  = pcnt_q + 1'b1;
          state_d = S_EMIT_P;
        end
      end
      S_EMIT_P: begin
        if (out_xfer) begin
          state_d = (pcnt_q < C_NUM_PILOT) ? S_GET_B : S_EMIT_TAIL;
        end
      end
      S_GET_B: begin
        if (in_xfer) begin
          b_re_d  = pilot_re;
          b_im_d  = pilot_im;
          pcnt_d  = pcnt_q + 1'b1;
          state_d = S_EMIT_1;
        end
      end
      S_EMIT_1: begin
        if (out_xfer) begin
          state_d = S_EMIT_2;
        end
      end
      S_EMIT_2: begin
        // The right-hand pilot becomes the left-hand pilot of the next gap.
        if (out_xfer) begin
          a_re_d  = b_re_q;
          a_im_d  = b_im_q;
          state_d = S_EMIT_P;
        end
      end
      S_EMIT_TAIL: begin
        if (out_xfer && (sc_idx_q == C_LAST_SC)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pilot_ready_d = (state_d == S_GET_A) || (state_d == S_GET_B);
    out_valid_d   = (state_d == S_EMIT_P) || (state_d == S_EMIT_1) ||
                    (state_d == S_EMIT_2) || (state_d == S_EMIT_TAIL);
    bypass_d      = (state_d == S_EMIT_P) || (state_d == S_EMIT_TAIL);
    done_d        = (state_d == S_DONE);
    sum_re_d      = '0;
    sum_im_d      = '0;
    case (state_d)
      S_EMIT_P, S_EMIT_TAIL: begin
        sum_re_d = ext_a_re;
        sum_im_d = ext_a_im;
      end
      S_EMIT_1: begin
        sum_re_d = {ext_a_re[SUM_WIDTH-2:0], 1'b0} + ext_b_re;
        sum_im_d = {ext_a_im[SUM_WIDTH-2:0], 1'b0} + ext_b_im;
      end
      S_EMIT_2: begin
        sum_re_d = ext_a_re + {ext_b_re[SUM_WIDTH-2:0], 1'b0};
        sum_im_d = ext_a_im + {ext_b_im[SUM_WIDTH-2:0], 1'b0};
      end
      default: begin
        sum_re_d = '0;
        sum_im_d = '0;
      end
    endcase
  end

  assign pilot_ready = pilot_ready_q;
  assign out_valid   = out_valid_q;
  assign bypass      = bypass_q;
  assign done        = done_q;
  assign sum_re      = sum_re_q;
  assign sum_im      = sum_im_q;
  assign sc_idx      = sc_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_pilot_interp_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pilot_interp_seq
// Description : Directed self-checking bench for pilot_interp_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pilot_interp_seq;

  localparam int EST_W = 18;
  localparam int SUM_W = 20;
  localparam int SC_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, pilot_valid, pilot_ready;
  logic             out_valid, out_ready, bypass, done;
  logic [EST_W-1:0] pilot_re, pilot_im;
  logic [SUM_W-1:0] sum_re, sum_im;
  logic [SC_W-1:0]  sc_idx;

  int n_cmp = 0;
  int n_err = 0;
  int q_sc[$], q_re[$], q_im[$], q_bp[$];
  int pin_cnt = 0, done_cnt = 0, cyc = 0, last_x = 0, done_gap = 0;
  int p_re[4], p_im[4], exp_re[12], exp_im[12];
  int exp_bp[12] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1};

  pilot_interp_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pilot_valid (pilot_valid),
    .pilot_ready (pilot_ready),
    .pilot_re    (pilot_re),
    .pilot_im    (pilot_im),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum_re      (sum_re),
    .sum_im      (sum_im),
    .bypass      (bypass),
    .sc_idx      (sc_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Handshakes seen at the falling edge complete at the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (out_valid && out_ready) begin
      q_sc.push_back(int'(sc_idx));
      q_re.push_back(int'($signed(sum_re)));
      q_im.push_back(int'($signed(sum_im)));
      q_bp.push_back(int'(bypass));
      last_x = cyc;
    end
    if (pilot_valid && pilot_ready) pin_cnt++;
    if (done) begin
      done_cnt++;
      done_gap = cyc - last_x;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_pilots(input int v0, input int v1, input int v2, input int v3,
                            input bit im_same);
    p_re = '{v0, v1, v2, v3};
    for (int k = 0; k < 4; k++) p_im[k] = im_same ? p_re[k] : 0;
  endtask

  task automatic check_stream(input string name, input int base);
    check($sformatf("%s count", name), q_sc.size() - base, 12);
    for (int i = 0; i < 12; i++) begin
      if (base + i < q_sc.size()) begin
        check($sformatf("%s sc%0d idx", name, i), q_sc[base+i], i);
        check($sformatf("%s sc%0d re", name, i), q_re[base+i], exp_re[i]);
        check($sformatf("%s sc%0d im", name, i), q_im[base+i], exp_im[i]);
        check($sformatf("%s sc%0d bypass", name, i), q_bp[base+i], exp_bp[i]);
      end
    end
  endtask

  // mode 0: free-running, 1: 10-cycle stall at sc4, 2: starve GET_B + spurious start,
  // 3: reset at sc5
  task automatic run_symbol(input string name, input int mode);
    int  base_pin, base_done, base_out, idx, stall_n, starve_n, bad;
    int  snap_re, snap_im, snap_sc, snap_bp;
    bit  spur, complete, aborted;
    base_pin  = pin_cnt;
    base_done = done_cnt;
    base_out  = q_sc.size();
    stall_n = 0; starve_n = 0; bad = 0; spur = 0; complete = 0; aborted = 0;
    snap_re = 0; snap_im = 0; snap_sc = 0; snap_bp = 0;
    pilot_re    = EST_W'(p_re[0]);
    pilot_im    = EST_W'(p_im[0]);
    pilot_valid = 1'b1;
    out_ready   = 1'b1;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (q_sc.size() - base_out >= 12) begin
        complete = 1;
        break;
      end
      idx = pin_cnt - base_pin;
      pilot_re    = EST_W'(p_re[(idx < 4) ? idx : 3]);
      pilot_im    = EST_W'(p_im[(idx < 4) ? idx : 3]);
      pilot_valid = (idx < 4);
      out_ready   = 1'b1;
      start       = 1'b0;
      if (mode == 1 && out_valid && sc_idx == 4 && stall_n < 10) begin
        if (stall_n == 0) begin
          snap_re = int'($signed(sum_re)); snap_im = int'($signed(sum_im));
          snap_sc = int'(sc_idx);          snap_bp = int'(bypass);
        end else if (snap_re != int'($signed(sum_re)) || snap_im != int'($signed(sum_im)) ||
                     snap_sc != int'(sc_idx) || snap_bp != int'(bypass) || pilot_ready) begin
          bad++;
        end
        out_ready = 1'b0;
        stall_n++;
      end
      if (mode == 2 && pilot_ready && idx == 1 && starve_n < 5) begin
        if (out_valid) bad++;
        pilot_valid = 1'b0;
        starve_n++;
      end
      if (mode == 2 && out_valid && sc_idx == 6 && !spur) begin
        start = 1'b1;
        spur  = 1;
      end
      if (mode == 3 && out_valid && sc_idx == 5) begin
        rst_n = 1'b0;
        #1;
        check({name, " rst out_valid"}, out_valid, 0);
        check({name, " rst pilot_ready"}, pilot_ready, 0);
        check({name, " rst sc_idx"}, sc_idx, 0);
        check({name, " rst sum_re"}, $signed(sum_re), 0);
        check({name, " rst bypass"}, bypass, 0);
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
    end
    pilot_valid = 1'b0;
    out_ready   = 1'b1;
    start       = 1'b0;
    if (mode == 3) begin
      check({name, " reset reached"}, aborted, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check({name, " no done after reset"}, done_cnt - base_done, 0);
      check({name, " idle after reset"}, out_valid, 0);
    end else begin
      check({name, " completed"}, complete, 1);
      // This is the DONE cycle; a start here must be ignored.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check({name, " done pulses"}, done_cnt - base_done, 1);
      check({name, " done gap"}, done_gap, 1);
      check({name, " start in DONE ignored"}, pilot_ready, 0);
      check({name, " idle out_valid"}, out_valid, 0);
      check_stream(name, base_out);
      if (mode == 1) begin
        check({name, " stall cycles"}, stall_n, 10);
        check({name, " stall stability"}, bad, 0);
      end
      if (mode == 2) begin
        check({name, " starve cycles"}, starve_n, 5);
        check({name, " starve out_valid"}, bad, 0);
        check({name, " spurious start issued"}, spur, 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; pilot_valid = 1'b0; out_ready = 1'b1;
    pilot_re = '0; pilot_im = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pilot_ready", pilot_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset done", done, 0);
    check("reset bypass", bypass, 0);
    check("reset sum_re", $signed(sum_re), 0);
    check("reset sum_im", $signed(sum_im), 0);
    check("reset sc_idx", sc_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_pilots(3000, 6000, 9000, 12000, 0);
    exp_re = '{3000, 12000, 15000, 6000, 21000, 24000, 9000, 30000, 33000, 12000, 12000, 12000};
    exp_im = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_symbol("ramp", 0);

    set_pilots(-4096, 2048, -4096, 2048, 1);
    exp_re = '{-4096, -6144, 0, 2048, 0, -6144, -4096, -6144, 0, 2048, 2048, 2048};
    exp_im = exp_re;
    run_symbol("signed", 0);

    set_pilots(131071, 131071, 131071, 131071, 1);
    exp_re = '{131071, 393213, 393213, 131071, 393213, 393213, 131071, 393213, 393213,
               131071, 131071, 131071};
    exp_im = exp_re;
    run_symbol("maxpos", 0);

    set_pilots(-131072, -131072, -131072, -131072, 1);
    exp_re = '{-131072, -393216, -393216, -131072, -393216, -393216, -131072, -393216,
               -393216, -131072, -131072, -131072};
    exp_im = exp_re;
    run_symbol("maxneg", 0);

    set_pilots(3000, 6000, 9000, 12000, 0);
    exp_re = '{3000, 12000, 15000, 6000, 21000, 24000, 9000, 30000, 33000, 12000, 12000, 12000};
    exp_im = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_symbol("stall", 1);
    run_symbol("starve", 2);
    run_symbol("midreset", 3);
    run_symbol("postreset", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
